gpio_pad_ctrl: RTL
==================

# gpio_pad_ctrl

Register-programmed controller for a bank of `GPIO_NUM` tri-state pull pads. It drives each pad's output-enable, output value and pull-enable, and synchronizes and debounces each pad's input. It also detects edges on the input and raises a level interrupt. It sits between the SoC register bus and the tri-state pad cells in the chip IO ring.

## Interface
- `GPIO_NUM`, 8: number of pins (1..32).
- `DBNC_W`, 8: debounce counter width in bits.

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `wr_en_i` in 1: register write strobe, one write per cycle.
- `wr_addr_i` in 3: write address.
- `wr_data_i` in `GPIO_NUM`: write data.
- `rd_en_i` in 1: register read strobe.
- `rd_addr_i` in 3: read address.
- `rd_data_o` out `GPIO_NUM`: read data, registered.
- `gpio_out_o` out `GPIO_NUM`: per-pad output value (pad `i_i`).
- `gpio_oen_o` out `GPIO_NUM`: per-pad output enable, 1 = drive (pad `oen_i`).
- `gpio_ren_o` out `GPIO_NUM`: per-pad pull enable (pad `ren_i`).
- `gpio_in_i` in `GPIO_NUM`: per-pad input (pad `c_o`), asynchronous.
- `irq_o` out 1: interrupt, `|(PEND & IEN)`.

## Operation
- Register map (addr: name, access, reset):
  - 0: DIR, RW, 0. Drives `gpio_oen_o`.
  - 1: OUT, RW, 0. Drives `gpio_out_o`.
  - 2: PUEN, RW, 0. Drives `gpio_ren_o`.
  - 3: DBNC, RW, 0. Only the low `min(DBNC_W,GPIO_NUM)` bits are used; the rest read 0.
  - 4: IEN, RW, 0.
  - 5: ITYPE, RW, 0. 1 = rising edge, 0 = falling edge.
  - 6: PEND, W1C, 0.
  - 7: IN, RO. Holds the debounced value `stb`.
- Writes to address 7 are ignored.
- Pad outputs are direct register outputs. There is no combinational path from bus inputs to pads.
- Input path, per pin: `gpio_in_i` passes through two-flop synchronizer `s1`, `s2`, then the debouncer, then stable register `stb`.
- Debouncer, per pin, using counter `cnt[DBNC_W-1:0]`:
  - When `s2 == stb`: `cnt` <= 0.
  - When `s2 != stb` and `cnt == DBNC`: `stb` <= `s2` and `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt` + 1.
  - A mismatch must therefore persist for DBNC+1 consecutive cycles before `stb` changes.
  - DBNC = 0 means `stb` follows `s2` with one cycle of delay.
  - A glitch shorter than DBNC+1 cycles resets `cnt` and leaves `stb` unchanged.
- A DBNC write takes effect on the next compare. An in-flight `cnt` above the new DBNC continues counting, wraps at 2^DBNC_W and resolves on the next equality.
- Edge detect: `stb_q` is `stb` delayed one cycle.
  - rise = `stb & ~stb_q`; fall = `~stb & stb_q`.
  - `hit[i]` = ITYPE[i] ? rise[i] : fall[i].
- PEND update: `PEND[i]` <= (`PEND[i]` & ~w1c[i]) | (`hit[i]` & `IEN[i]`).
  - On a simultaneous set and W1C, set wins.
  - Clearing an IEN bit leaves its PEND bit untouched but masks it from `irq_o`.
- Reads: when `rd_en_i` is asserted, `rd_data_o` <= register[`rd_addr_i`] (0 for DBNC's unused bits). `rd_data_o` holds its value when `rd_en_i` is low.
- A read and a write to the same address in the same cycle return the pre-write value.

## Timing
- Reset: all outputs, registers, `s1`, `s2`, `stb`, `stb_q`, `cnt` and `rd_data_o` are 0. `irq_o` = 0.
- A pad held high through reset produces a post-reset rising edge, but IEN = 0 so PEND stays 0.
- Register write at edge E: pad outputs change after E, valid in cycle E+1.
- Read latency: 1 cycle.
- Pad input latency, for an input stable from before edge E:
  - `s1` updates at E, `s2` at E+1, `stb` at E+2+DBNC.
  - PEND and `irq_o` assert at E+3+DBNC.
- W1C of PEND at edge E: `irq_o` deasserts after E, unless a new hit occurs in the same cycle.
- `rst_i` asserted mid-debounce or mid-interrupt clears all state immediately (asynchronous). Release is synchronous to `clk_i`, handled externally.

## Configuration
- `GPIO_PAD_CTRL_DBNC_EN` defined: debouncer, `cnt` and the DBNC register are present as described above.
- Macro undefined:
  - No `cnt` or DBNC storage.
  - `stb` <= `s2` every cycle (behaves as DBNC = 0).
  - Address 3 reads 0 and writes to it are ignored.
  - Input latency is fixed: `stb` at E+2, `irq_o` at E+3.

## Test plan
- Reset release with `gpio_in_i` = 0xFF and IEN = 0: all outputs are 0 and `irq_o` stays 0. Reading IN returns 0xFF by the 4th cycle.
- Write DIR = 0xA5, OUT = 0x0F, PUEN = 0x3C: the next cycle shows `gpio_oen_o` = 0xA5, `gpio_out_o` = 0x0F, `gpio_ren_o` = 0x3C. Reads return the same values with 1-cycle latency.
- DBNC = 4 (macro defined):
  - A 3-cycle high pulse on pin 0 leaves IN[0] = 0.
  - A 5-cycle high pulse sets IN[0] = 1 exactly at E+6.
- IEN = 0x01, ITYPE = 0x01, rising edge on pin 0 with DBNC = 0: `irq_o` rises at E+3 and PEND = 0x01. W1C 0x01 drops `irq_o` the next cycle.
- W1C of PEND[1] in the same cycle as a new falling-edge hit on pin 1 (ITYPE[1] = 0, IEN[1] = 1): PEND[1] stays 1 and `irq_o` stays 1.
- `rst_i` pulsed while `cnt` = 3 and PEND = 0x02: all state is 0 immediately. After release, the debounce restarts from `cnt` = 0.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// Register-programmed tri-state pad bank: direction/output/pull registers, synchronized and
// debounced inputs, edge-detect interrupts. Debouncer present only with GPIO_PAD_CTRL_DBNC_EN.
module gpio_pad_ctrl #(
  parameter int unsigned GPIO_NUM = 8,
  parameter int unsigned DBNC_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [2:0]          wr_addr_i,
  input  logic [GPIO_NUM-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic [2:0]          rd_addr_i,
  output logic [GPIO_NUM-1:0] rd_data_o,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_oen_o,
  output logic [GPIO_NUM-1:0] gpio_ren_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic                irq_o
);

  localparam logic [2:0] AddrDir   = 3'd0;
  localparam logic [2:0] AddrOut   = 3'd1;
  localparam logic [2:0] AddrPuen  = 3'd2;
  localparam logic [2:0] AddrDbnc  = 3'd3;
  localparam logic [2:0] AddrIen   = 3'd4;
  localparam logic [2:0] AddrItype = 3'd5;
  localparam logic [2:0] AddrPend  = 3'd6;
  localparam logic [2:0] AddrIn    = 3'd7;

  localparam int unsigned DbncBits = (DBNC_W < GPIO_NUM) ? DBNC_W : GPIO_NUM;

  logic [GPIO_NUM-1:0] dir_q, out_q, puen_q, ien_q, itype_q, pend_q, pend_d;
  logic [GPIO_NUM-1:0] s1_q, s2_q, stb_q, stb_d, stb_prev_q;
  logic [GPIO_NUM-1:0] rd_data_q, rd_data_d, dbnc_rd;
  logic [GPIO_NUM-1:0] w1c, rise, fall, hit;
  logic [7:0]          wr_sel;

  always_comb begin
    wr_sel = '0;
    if (wr_en_i) wr_sel[wr_addr_i] = 1'b1;
  end

  assign w1c  = wr_sel[AddrPend] ? wr_data_i : '0;
  assign rise = stb_q & ~stb_prev_q;
  assign fall = ~stb_q & stb_prev_q;
  assign hit  = (itype_q & rise) | (~itype_q & fall);
  // A new hit overrides a same-cycle clear.
  assign pend_d = (pend_q & ~w1c) | (hit & ien_q);

`ifdef GPIO_PAD_CTRL_DBNC_EN
  logic [DbncBits-1:0] dbnc_q;
  logic [DBNC_W-1:0]   dbnc_ext;
  logic [DBNC_W-1:0]   cnt_q [GPIO_NUM];
  logic [DBNC_W-1:0]   cnt_d [GPIO_NUM];

  always_comb begin
    dbnc_ext                = '0;
    dbnc_ext[DbncBits-1:0]  = dbnc_q;
    dbnc_rd                 = '0;
    dbnc_rd[DbncBits-1:0]   = dbnc_q;
  end

  // Counter only resolves on equality, so a count above a lowered DBNC wraps first.
  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < int'(GPIO_NUM); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == dbnc_ext) begin
        stb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DBNC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbnc_q <= '0;
      for (int i = 0; i < int'(GPIO_NUM); i++) cnt_q[i] <= '0;
    end else begin
      if (wr_sel[AddrDbnc]) dbnc_q <= wr_data_i[DbncBits-1:0];
      for (int i = 0; i < int'(GPIO_NUM); i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign stb_d   = s2_q;
  assign dbnc_rd = '0;
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      case (rd_addr_i)
        AddrDir:   rd_data_d = dir_q;
        AddrOut:   rd_data_d = out_q;
        AddrPuen:  rd_data_d = puen_q;
        AddrDbnc:  rd_data_d = dbnc_rd;
        AddrIen:   rd_data_d = ien_q;
        AddrItype: rd_data_d = itype_q;
        AddrPend:  rd_data_d = pend_q;
        AddrIn:    rd_data_d = stb_q;
        default:   rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q      <= '0;
      out_q      <= '0;
      puen_q     <= '0;
      ien_q      <= '0;
      itype_q    <= '0;
      pend_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      stb_q      <= '0;
      stb_prev_q <= '0;
      rd_data_q  <= '0;
    end else begin
      if (wr_sel[AddrDir])   dir_q   <= wr_data_i;
      if (wr_sel[AddrOut])   out_q   <= wr_data_i;
      if (wr_sel[AddrPuen])  puen_q  <= wr_data_i;
      if (wr_sel[AddrIen])   ien_q   <= wr_data_i;
      if (wr_sel[AddrItype]) itype_q <= wr_data_i;
      pend_q     <= pend_d;
      s1_q       <= gpio_in_i;
      s2_q       <= s1_q;
      stb_q      <= stb_d;
      stb_prev_q <= stb_q;
      rd_data_q  <= rd_data_d;
    end
  end

  assign gpio_oen_o = dir_q;
  assign gpio_out_o = out_q;
  assign gpio_ren_o = puen_q;
  assign rd_data_o  = rd_data_q;
  assign irq_o      = |(pend_q & ien_q);

endmodule
